// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: multiplier FSM states, widths, and sign-magnitude helpers.
package picomips_pkg;

   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

   // |x| of the most negative value wraps to 2^(DATA_W-1), which is correct read as unsigned.
   function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] x);
      return x[DATA_W-1] ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [2*DATA_W-1:0] neg_acc(input logic [2*DATA_W-1:0] x);
      return ~x + 1'b1;
   endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative signed shift-add multiplier: one partial product per clock, n RUN cycles,
// then a one-cycle DONE write-back; stall holds fetch from accept through the last RUN cycle.
module seq_mult
   import picomips_pkg::*;
#(
   parameter int n = DATA_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [n-1:0]          a,
   input  logic [n-1:0]          b,
   input  logic [REG_ADDR_W-1:0] dest,
   output logic                  stall,
   output logic                  busy,
   output logic                  w,
   output logic [REG_ADDR_W-1:0] waddr,
   output logic [2*n-1:0]        prod
);

   localparam int CW = $clog2(n);

   mult_state_t     state, next_state;
   logic [n-1:0]    mcand, mplier;
   logic [2*n-1:0]  acc, acc_next;
   logic [CW-1:0]   count;
   logic            sign;
   logic            last_iter;

   assign last_iter = (count == CW'(n - 1));

   always_comb begin
      next_state = state;
      acc_next   = acc;
      if (mplier[0])
         acc_next = acc + ({{n{1'b0}}, mcand} << count);
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_iter) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         sign   <= 1'b0;
         waddr  <= '0;
         prod   <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: if (start) begin
               mcand  <= abs_op(a);
               mplier <= abs_op(b);
               sign   <= a[n-1] ^ b[n-1];
               waddr  <= dest;
               acc    <= '0;
               count  <= '0;
            end
            RUN: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               // Final partial product is folded in here so prod is ready for the DONE cycle.
               if (last_iter)
                  prod <= sign ? neg_acc(acc_next) : acc_next;
            end
            default: ;
         endcase
      end
   end

   assign stall = ((state == IDLE) && start) || (state == RUN);
   assign busy  = (state != IDLE);
   assign w     = (state == DONE) && !reset;

endmodule

// File: tb/tb_seq_mult.sv
// Randomized and directed checks of seq_mult against a cycle-count behavioural model.
module tb_seq_mult;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [7:0]  a, b;
   logic [2:0]  dest;
   logic        stall, busy, w;
   logic [2:0]  waddr;
   logic [15:0] prod;

   int tests = 0, fails = 0;
   int accepts = 0, wcount = 0;
   bit chk_en = 1'b0;

   // Model: t counts cycles since accept (0 = idle, 1..N = run, N+1 = write-back).
   int          t = 0;
   logic [15:0] m_exp = '0, m_prod = '0;
   logic [2:0]  m_waddr = '0;

   seq_mult #(.n(N)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .dest(dest),
      .stall(stall), .busy(busy), .w(w), .waddr(waddr), .prod(prod)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mult_ref(input logic [7:0] x, input logic [7:0] y);
      int r;
      r = int'($signed(x)) * int'($signed(y));
      return 16'(r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         t = 0; m_prod = '0; m_waddr = '0;
      end else if (t == 0) begin
         if (start) begin
            t = 1; m_exp = mult_ref(a, b); m_waddr = dest; accepts++;
         end
      end else if (t == N + 1) begin
         t = 0;
      end else begin
         t++;
         if (t == N + 1) m_prod = m_exp;
      end
   end

   always @(negedge clk) begin
      if (w === 1'b1) wcount++;
      if (chk_en) begin
         chk("stall", 32'(stall), 32'(((t >= 1) && (t <= N)) || ((t == 0) && start)));
         chk("busy",  32'(busy),  32'(t != 0));
         chk("w",     32'(w),     32'((t == N + 1) && !reset));
         chk("prod",  32'(prod),  32'(m_prod));
         chk("waddr", 32'(waddr), 32'(m_waddr));
      end
   end

   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] id,
                         output logic [15:0] p, output logic [2:0] wa, output int lat, output int stalls);
      @(posedge clk); #1;
      a = ia; b = ib; dest = id; start = 1'b1;
      @(negedge clk);
      stalls = int'(stall); lat = 0;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); dest = 3'($urandom);
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (w) break;
         stalls += int'(stall);
      end
      p = prod; wa = waddr;
   endtask

   logic [15:0] p;
   logic [2:0]  wa;
   int lat, stalls, wc0;

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0; dest = '0;
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_prod", 32'(prod), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_busy_stall_w", {29'd0, busy, stall, w}, 0);
      @(posedge clk); #1 reset = 1'b0;

      chk("ref_m7x9", 32'(mult_ref(8'hF9, 8'd9)), 32'h0000FFC1);
      chk("ref_m128x127", 32'(mult_ref(8'h80, 8'd127)), 32'h0000C080);

      run_op(8'd3, 8'd5, 3'd2, p, wa, lat, stalls);
      chk("t1_prod", 32'(p), 32'h000F);
      chk("t1_waddr", 32'(wa), 2);
      chk("t1_stall_cycles", 32'(stalls), 9);
      chk("t1_latency", 32'(lat), N + 1);

      run_op(8'h80, 8'h80, 3'd7, p, wa, lat, stalls);
      chk("t2_m128sq", 32'(p), 32'h4000);
      run_op(8'h80, 8'd127, 3'd0, p, wa, lat, stalls);
      chk("t2_m128x127", 32'(p), 32'hC080);
      chk("t2_dest0", 32'(wa), 0);

      run_op(8'hF9, 8'd9, 3'd5, p, wa, lat, stalls);
      chk("t3_m7x9", 32'(p), 32'hFFC1);
      run_op(8'd0, 8'hFF, 3'd1, p, wa, lat, stalls);
      chk("t3_zero", 32'(p), 0);
      chk("t3_zero_latency", 32'(lat), N + 1);

      // start held high across an operation; mid-RUN operand changes must be ignored.
      @(posedge clk); #1;
      a = 8'd2; b = 8'd3; dest = 3'd4; start = 1'b1;
      @(posedge clk); #1;
      a = 8'd4; b = 8'd5; dest = 3'd6;
      lat = 0;
      while (lat < 20) begin @(negedge clk); lat++; if (w) break; end
      chk("t4_first_prod", 32'(prod), 6);
      chk("t4_first_waddr", 32'(waddr), 4);
      @(negedge clk);
      chk("t4_reaccept_stall", 32'(stall), 1);
      @(posedge clk); #1 start = 1'b0;
      lat = 0;
      while (lat < 20) begin @(negedge clk); lat++; if (w) break; end
      chk("t4_second_prod", 32'(prod), 20);
      chk("t4_second_lat", 32'(lat), N + 1);

      // Reset during the 4th RUN cycle.
      @(posedge clk); #1;
      a = 8'd5; b = 8'd6; dest = 3'd3; start = 1'b1;
      wc0 = wcount;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_stall", 32'(stall), 0);
      chk("t5_prod", 32'(prod), 0);
      repeat (15) @(negedge clk);
      chk("t5_no_w", 32'(wcount - wc0), 0);

      // Random traffic: start toggles every cycle, operands change freely.
      wc0 = wcount;
      begin
         int acc0, cyc;
         acc0 = accepts; cyc = 0;
         while ((accepts - acc0) < 1000 && cyc < 30000) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); dest = 3'($urandom);
            cyc++;
         end
         start = 1'b0;
         repeat (N + 4) @(posedge clk);
         @(negedge clk);
         chk("t6_accept_count", 32'(accepts - acc0), 1000);
         chk("t6_w_vs_accepts", 32'(wcount - wc0), 32'(accepts - acc0));
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
